// File: rtl/cpu_decode.sv
// mox125 decode stage: splits fetch words into form, register fields, immediate and
// class flags, registers them for execute, and inserts one bubble on load-use hazards.
module cpu_decode #(
  parameter bit ENABLE_HAZARD = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] opcode_i,
  input  logic [31:0] operand_i,
  input  logic        valid_i,
  input  logic [31:0] PC_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [3:0]  rf_ra_o,
  output logic [3:0]  rf_rb_o,
  output logic        valid_o,
  output logic [31:0] PC_o,
  output logic [15:0] opcode_o,
  output logic [1:0]  form_o,
  output logic [3:0]  regA_o,
  output logic [3:0]  regB_o,
  output logic [31:0] imm_o,
  output logic        long_o,
  output logic        load_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {
    FORM1 = 2'd0,
    FORM2 = 2'd2,
    FORM3 = 2'd3
  } form_e;

  form_e       form;
  logic [7:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        is_long;
  logic        is_load;
  logic        is_illegal;
  logic [31:0] imm;
  logic        hazard;

  logic        valid_d,   valid_q;
  logic [31:0] pc_d,      pc_q;
  logic [15:0] opcode_d,  opcode_q;
  logic [1:0]  form_d,    form_q;
  logic [3:0]  rega_d,    rega_q;
  logic [3:0]  regb_d,    regb_q;
  logic [31:0] imm_d,     imm_q;
  logic        long_d,    long_q;
  logic        load_d,    load_q;
  logic        illegal_d, illegal_q;
  logic        ld_v_d,    ld_v_q;
  logic [3:0]  ld_reg_d,  ld_reg_q;

  // Field extraction and classification of the word currently offered by fetch.
  always_comb begin
    if (!opcode_i[15])      form = FORM1;
    else if (!opcode_i[14]) form = FORM2;
    else                    form = FORM3;

    op = opcode_i[15:8];
    ra = (form == FORM2) ? opcode_i[11:8] : opcode_i[7:4];
    rb = opcode_i[3:0];

    is_long = 1'b0;
    is_load = 1'b0;
    if (form == FORM1) begin
      case (op)
        8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
        8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39: is_long = 1'b1;
        default: is_long = 1'b0;
      endcase
      case (op)
        8'h08, 8'h0A, 8'h0C, 8'h1C, 8'h1D, 8'h21, 8'h22, 8'h36, 8'h38: is_load = 1'b1;
        default: is_load = 1'b0;
      endcase
    end
    is_illegal = (form == FORM1) && ((op == 8'h00) || (op > 8'h3F));

    if (is_long)             imm = operand_i;
    else if (form == FORM2)  imm = {24'h0, opcode_i[7:0]};
    else if (form == FORM3)  imm = {{21{opcode_i[9]}}, opcode_i[9:0], 1'b0};
    else                     imm = 32'h0;

    // Conservative read set: form1 reads rA and rB, form2 reads rA, form3 reads nothing.
    hazard = 1'b0;
    if (ENABLE_HAZARD && valid_i && ld_v_q) begin
      if (form == FORM1)      hazard = (ra == ld_reg_q) || (rb == ld_reg_q);
      else if (form == FORM2) hazard = (ra == ld_reg_q);
      else                    hazard = 1'b0;
    end
  end

  assign stall_o = !flush_i && (stall_i || hazard);
  assign rf_ra_o = ra;
  assign rf_rb_o = rb;

  // NOTE: every _d starts as its _q so each branch below only lists what changes;
  // with that default no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    form_d    = form_q;
    rega_d    = rega_q;
    regb_d    = regb_q;
    imm_d     = imm_q;
    long_d    = long_q;
    load_d    = load_q;
    illegal_d = illegal_q;
    ld_v_d    = ld_v_q;
    ld_reg_d  = ld_reg_q;

    if (flush_i) begin
      valid_d = 1'b0;
      ld_v_d  = 1'b0;
    end else if (stall_i) begin
      // execute is full: everything holds
    end else if (hazard) begin
      valid_d = 1'b0;
      ld_v_d  = 1'b0;
    end else begin
      valid_d   = valid_i;
      pc_d      = PC_i;
      opcode_d  = opcode_i;
      form_d    = form;
      rega_d    = ra;
      regb_d    = rb;
      imm_d     = imm;
      long_d    = is_long;
      load_d    = is_load;
      illegal_d = is_illegal;
      ld_v_d    = valid_i && is_load;
      ld_reg_d  = ra;
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
  // order of these statements cannot create a simulation/synthesis mismatch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      pc_q      <= 32'h0;
      opcode_q  <= 16'h0;
      form_q    <= 2'd0;
      rega_q    <= 4'h0;
      regb_q    <= 4'h0;
      imm_q     <= 32'h0;
      long_q    <= 1'b0;
      load_q    <= 1'b0;
      illegal_q <= 1'b0;
      ld_v_q    <= 1'b0;
      ld_reg_q  <= 4'h0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      form_q    <= form_d;
      rega_q    <= rega_d;
      regb_q    <= regb_d;
      imm_q     <= imm_d;
      long_q    <= long_d;
      load_q    <= load_d;
      illegal_q <= illegal_d;
      ld_v_q    <= ld_v_d;
      ld_reg_q  <= ld_reg_d;
    end
  end

  assign valid_o   = valid_q;
  assign PC_o      = pc_q;
  assign opcode_o  = opcode_q;
  assign form_o    = form_q;
  assign regA_o    = rega_q;
  assign regB_o    = regb_q;
  assign imm_o     = imm_q;
  assign long_o    = long_q;
  assign load_o    = load_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_cpu_decode.sv
// Self-checking bench for cpu_decode: table-driven decode vectors through a scoreboard,
// then directed load-use, stall, flush and reset sequences.
module tb_cpu_decode;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] opcode_i;
  logic [31:0] operand_i;
  logic        valid_i;
  logic [31:0] PC_i;
  logic        stall_i;
  logic        flush_i;
  logic        stall_o;
  logic [3:0]  rf_ra_o;
  logic [3:0]  rf_rb_o;
  logic        valid_o;
  logic [31:0] PC_o;
  logic [15:0] opcode_o;
  logic [1:0]  form_o;
  logic [3:0]  regA_o;
  logic [3:0]  regB_o;
  logic [31:0] imm_o;
  logic        long_o;
  logic        load_o;
  logic        illegal_o;

  int n_cmp  = 0;
  int n_fail = 0;

  cpu_decode #(.ENABLE_HAZARD(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .operand_i(operand_i),
    .valid_i(valid_i), .PC_i(PC_i), .stall_i(stall_i), .flush_i(flush_i),
    .stall_o(stall_o), .rf_ra_o(rf_ra_o), .rf_rb_o(rf_rb_o), .valid_o(valid_o),
    .PC_o(PC_o), .opcode_o(opcode_o), .form_o(form_o), .regA_o(regA_o),
    .regB_o(regB_o), .imm_o(imm_o), .long_o(long_o), .load_o(load_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] opc;
    logic [31:0] opnd;
    logic [31:0] pc;
    logic [1:0]  form;
    logic        chk_regs;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] imm;
    logic        lng;
    logic        ld;
    logic        ill;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];
  vec_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] opc, input logic [31:0] opnd, input logic [31:0] pc,
                       input logic v, input logic st, input logic fl);
    opcode_i  = opc;
    operand_i = opnd;
    PC_i      = pc;
    valid_i   = v;
    stall_i   = st;
    flush_i   = fl;
    #1;
  endtask

  task automatic compare_out(input vec_t e);
    check("opcode_o", {16'h0, opcode_o}, {16'h0, e.opc});
    check("PC_o", PC_o, e.pc);
    check("form_o", {30'h0, form_o}, {30'h0, e.form});
    if (e.chk_regs) begin
      check("regA_o", {28'h0, regA_o}, {28'h0, e.ra});
      check("regB_o", {28'h0, regB_o}, {28'h0, e.rb});
    end
    check("imm_o", imm_o, e.imm);
    check("long_o", {31'h0, long_o}, {31'h0, e.lng});
    check("load_o", {31'h0, load_o}, {31'h0, e.ld});
    check("illegal_o", {31'h0, illegal_o}, {31'h0, e.ill});
  endtask

  initial begin
    //               opc       operand       pc        form chk ra   rb   imm           lng  ld   ill
    vecs[0]  = '{16'h0110, 32'h12345678, 32'h1000, 2'd0, 1'b1, 4'h1, 4'h0, 32'h12345678, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{16'h8105, 32'hDEADBEEF, 32'h1006, 2'd2, 1'b1, 4'h1, 4'h5, 32'h00000005, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'hC3FF, 32'h0,        32'h1008, 2'd3, 1'b0, 4'h0, 4'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h4000, 32'h0,        32'h100A, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{16'h0A23, 32'h00000055, 32'h100C, 2'd0, 1'b1, 4'h2, 4'h3, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'h0C45, 32'hCAFEF00D, 32'h100E, 2'd0, 1'b1, 4'h4, 4'h5, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16'h8AFF, 32'h0,        32'h1014, 2'd2, 1'b1, 4'hA, 4'hF, 32'h000000FF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'hC200, 32'h0,        32'h1016, 2'd3, 1'b0, 4'h0, 4'h0, 32'hFFFFFC00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'hC001, 32'h0,        32'h1018, 2'd3, 1'b0, 4'h0, 4'h0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h0000, 32'h0,        32'h101A, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{16'h3F12, 32'h0,        32'h101C, 2'd0, 1'b1, 4'h1, 4'h2, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h3912, 32'h11112222, 32'h101E, 2'd0, 1'b1, 4'h1, 4'h2, 32'h11112222, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{16'h2100, 32'h0,        32'h1024, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b1, 1'b0};

    rst_i = 1'b1;
    drive(16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check("rst_valid_o", {31'h0, valid_o}, 32'h0);
    check("rst_long_o", {31'h0, long_o}, 32'h0);
    check("rst_load_o", {31'h0, load_o}, 32'h0);
    check("rst_illegal_o", {31'h0, illegal_o}, 32'h0);
    check("rst_PC_o", PC_o, 32'h0);
    check("rst_imm_o", imm_o, 32'h0);
    check("rst_opcode_o", {16'h0, opcode_o}, 32'h0);
    check("rst_stall_o", {31'h0, stall_o}, 32'h0);
    rst_i = 1'b0;

    // Back-to-back independent decode vectors through the scoreboard.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].opc, vecs[i].opnd, vecs[i].pc, 1'b1, 1'b0, 1'b0);
      check("tbl_stall_o", {31'h0, stall_o}, 32'h0);
      if (vecs[i].chk_regs) begin
        check("rf_ra_o", {28'h0, rf_ra_o}, {28'h0, vecs[i].ra});
        check("rf_rb_o", {28'h0, rf_rb_o}, {28'h0, vecs[i].rb});
      end
      sb.push_back(vecs[i]);
      tick();
      check("tbl_valid_o", {31'h0, valid_o}, 32'h1);
      if (valid_o && sb.size() > 0) compare_out(sb.pop_front());
    end
    drive(16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle_valid_o", {31'h0, valid_o}, 32'h0);
    check("sb_drained", sb.size(), 32'h0);

    // Load-use: exactly one bubble.
    drive(16'h0A23, 32'h0, 32'h2000, 1'b1, 1'b0, 1'b0);
    check("lu_first_stall_o", {31'h0, stall_o}, 32'h0);
    tick();
    check("lu_ld_valid_o", {31'h0, valid_o}, 32'h1);
    check("lu_ld_opcode_o", {16'h0, opcode_o}, 32'h0A23);
    drive(16'h0542, 32'h0, 32'h2002, 1'b1, 1'b0, 1'b0);
    check("lu_hazard_stall_o", {31'h0, stall_o}, 32'h1);
    tick();
    check("lu_bubble_valid_o", {31'h0, valid_o}, 32'h0);
    check("lu_after_stall_o", {31'h0, stall_o}, 32'h0);
    tick();
    check("lu_use_valid_o", {31'h0, valid_o}, 32'h1);
    check("lu_use_opcode_o", {16'h0, opcode_o}, 32'h0542);
    check("lu_use_PC_o", PC_o, 32'h2002);

    // No hazard: consumer reads different registers.
    drive(16'h0A23, 32'h0, 32'h3000, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0545, 32'h0, 32'h3002, 1'b1, 1'b0, 1'b0);
    check("nh_stall_o", {31'h0, stall_o}, 32'h0);
    tick();
    check("nh_valid_o", {31'h0, valid_o}, 32'h1);
    check("nh_opcode_o", {16'h0, opcode_o}, 32'h0545);

    // stall_i holds the pipeline register for 3 cycles.
    drive(16'h0542, 32'h0, 32'h4000, 1'b1, 1'b0, 1'b0);
    tick();
    check("st_issue_opcode_o", {16'h0, opcode_o}, 32'h0542);
    drive(16'h0110, 32'h12345678, 32'h4002, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check("st_stall_o", {31'h0, stall_o}, 32'h1);
      tick();
      check("st_hold_opcode_o", {16'h0, opcode_o}, 32'h0542);
      check("st_hold_PC_o", PC_o, 32'h4000);
      check("st_hold_valid_o", {31'h0, valid_o}, 32'h1);
      check("st_hold_long_o", {31'h0, long_o}, 32'h0);
    end
    drive(16'h0110, 32'h12345678, 32'h4002, 1'b1, 1'b0, 1'b0);
    check("st_release_stall_o", {31'h0, stall_o}, 32'h0);
    tick();
    check("st_adv_opcode_o", {16'h0, opcode_o}, 32'h0110);
    check("st_adv_imm_o", imm_o, 32'h12345678);

    // Flush with stall during a pending load-use hazard.
    drive(16'h0A23, 32'h0, 32'h5000, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0542, 32'h0, 32'h5002, 1'b1, 1'b1, 1'b1);
    check("fl_stall_o", {31'h0, stall_o}, 32'h0);
    tick();
    check("fl_valid_o", {31'h0, valid_o}, 32'h0);
    drive(16'h0542, 32'h0, 32'h5002, 1'b1, 1'b0, 1'b0);
    check("fl_ldv_cleared_stall_o", {31'h0, stall_o}, 32'h0);
    tick();
    check("fl_next_valid_o", {31'h0, valid_o}, 32'h1);
    check("fl_next_opcode_o", {16'h0, opcode_o}, 32'h0542);

    // Reset in the middle of a hazard.
    drive(16'h0A23, 32'h0, 32'h6000, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0542, 32'h0, 32'h6002, 1'b1, 1'b0, 1'b0);
    check("rh_stall_o", {31'h0, stall_o}, 32'h1);
    rst_i = 1'b1;
    tick();
    check("rh_valid_o", {31'h0, valid_o}, 32'h0);
    check("rh_load_o", {31'h0, load_o}, 32'h0);
    check("rh_stall_o_dropped", {31'h0, stall_o}, 32'h0);
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_decode.md
Name: cpu_decode

Overview:
Instruction decode stage of the mox125 pipeline, directly downstream of cpu_fetch. It consumes the opcode, operand, valid and PC presented by the fetch unit's instruction FIFO. Each instruction is split into moxie form, register fields, a normalised immediate and class flags, then latched into the decode/execute pipeline register. It detects load-use hazards against the instruction it issued in the previous cycle, inserts a bubble when one occurs, and back-pressures fetch through stall_o.

Parameters:
- ENABLE_HAZARD, 1: 1 enables load-use bubble insertion; 0 forces the hazard term to 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- opcode_i  in  16  instruction word from fetch
- operand_i  in  32  trailing 32-bit operand from fetch; meaningful only for long-form instructions
- valid_i  in  1  opcode_i/operand_i/PC_i hold a real instruction
- PC_i  in  32  address of opcode_i
- stall_i  in  1  execute stage cannot accept a new instruction
- flush_i  in  1  branch taken; discard the in-flight instruction
- stall_o  out  1  to fetch stall_i
- rf_ra_o  in/out: out  4  register-file read index A, combinational from opcode_i[7:4] (form 1) or opcode_i[11:8] (form 2)
- rf_rb_o  out  4  register-file read index B, combinational opcode_i[3:0]
- valid_o  out  1  pipeline register holds an instruction
- PC_o  out  32  registered PC_i
- opcode_o  out  16  registered opcode
- form_o  out  2  0 = form1, 2 = form2, 3 = form3
- regA_o, regB_o  out  4 each  registered register fields
- imm_o  out  32  normalised immediate
- long_o  out  1  instruction carries a 32-bit operand
- load_o  out  1  instruction writes rA from memory
- illegal_o  out  1  undefined opcode

Behaviour:
- Reset: valid_o, long_o, load_o and illegal_o are 0. All other registered outputs are 0. The hazard tracker is cleared.
- Form: opcode_i[15]=0 gives form1 (op = opcode_i[15:8], rA=[7:4], rB=[3:0]). [15:14]=10 gives form2 (rA=[11:8], imm8=[7:0]). [15:14]=11 gives form3 (cond=[13:10], off10=[9:0]).
- imm_o by form:
  - long form: operand_i.
  - form2: zero-extended imm8.
  - form3: sign-extended off10 shifted left by 1.
  - otherwise: 0.
- Long-form op set: 01, 03, 08, 09, 0C, 0D, 1A, 1B, 1D, 1F, 20, 22, 24, 36, 37, 38, 39 (hex).
- Load op set: 08, 0A, 0C, 1C, 1D, 21, 22, 36, 38.
- illegal = form1 and (op == 00 or op > 3F). Illegal instructions still propagate with valid_o=1.
- Read set, conservative: form1 reads rA and rB. Form2 reads rA. Form3 reads nothing.
- Hazard tracker: ld_v plus ld_reg[3:0].
  - hazard = ENABLE_HAZARD & valid_i & ld_v & (read-set contains ld_reg).
- stall_o = !flush_i & (stall_i | hazard). It is combinational.
- Priority at posedge, highest first:
  1. rst_i: reset.
  2. flush_i: valid_o <= 0; ld_v <= 0. Flush overrides stall_i.
  3. stall_i: every output register and the tracker hold.
  4. hazard: valid_o <= 0 (bubble); ld_v <= 0. opcode_i is held by fetch and issues on the next cycle.
  5. Otherwise: all fields latch from the inputs; valid_o <= valid_i; ld_v <= valid_i & load; ld_reg <= rA.
- Latency: 1 cycle from valid_i to valid_o.
- A load-use pair gives exactly 1 bubble. Back-to-back independent instructions issue every cycle.
- With valid_i=0 and no stall, valid_o <= 0 and ld_v <= 0. Payload registers may update; they are don't-care while valid_o=0.
- Reset mid-stall or mid-hazard clears everything; stall_o drops in the same cycle once the reset value of ld_v takes effect.

Test Plan:
- Reset, then feed valid_i=1, opcode 0x0110, operand 0x12345678, PC 0x1000 → next cycle: valid_o=1, form_o=0, regA_o=1, long_o=1, imm_o=0x12345678, PC_o=0x1000, load_o=0.
- Load-use: 0x0A23 (ld.l $r2,($r3)) then 0x0542 (add.l $r4,$r2) → after the ld issues, stall_o=1 for 1 cycle. valid_o sequence is 1, 0, 1. 0x0542 appears on the third cycle.
- No hazard: 0x0A23 then 0x0545 (reads r4 and r5) → stall_o stays 0 and the two instructions issue on consecutive cycles.
- Form decode: 0x8105 → form_o=2, regA_o=1, imm_o=0x00000005. 0xC3FF → form_o=3, imm_o=0xFFFFFFFE. 0x4000 → illegal_o=1, valid_o=1.
- stall_i=1 for 3 cycles while the outputs hold 0x0542 → all outputs are unchanged and stall_o=1. Releasing stall_i advances the next instruction.
- flush_i=1 together with stall_i=1 during a pending load-use hazard → stall_o=0, next valid_o=0, ld_v cleared. A following 0x0542 issues without a bubble.
